lcd_msg_arbiter: RTL

- Shares the 16x2 character LCD between two message sources, e.g. the plaintext and ciphertext paths.
- Runs the power-up init sequence, then round-robin arbitrates 32-character (256-bit) message requests.
- Streams each granted message to the LCD with real bus timing: setup, enable pulse, per-command wait.
- Replaces free-running divided-clock sequencing; all logic runs on CLOCK.

---
 rtl/lcd_pkg.sv | 34 +++
 rtl/lcd_msg_arbiter_byte_writer.sv | 86 ++++++++
 rtl/lcd_msg_arbiter.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/lcd_pkg.sv
// lcd_pkg: shared constants and types for the LCD message arbiter.
//   - HD44780-style command bytes used by init and message framing
//   - top-level state encoding
//   - MSG_BYTES: byte writes per message (line1 addr + 16 chars + line2 addr + 16 chars)
package lcd_pkg;

  localparam logic [7:0] LCD_FUNC_SET = 8'h38;
  localparam logic [7:0] LCD_DISP_ON  = 8'h0C;
  localparam logic [7:0] LCD_ENTRY    = 8'h06;
  localparam logic [7:0] LCD_CLEAR    = 8'h01;
  localparam logic [7:0] LCD_LINE1    = 8'h80;
  localparam logic [7:0] LCD_LINE2    = 8'hC0;

  localparam int MSG_BYTES = 34;

  typedef enum logic [2:0] {
    ST_PWR, ST_INIT, ST_IDLE, ST_GRANT, ST_XFER, ST_DONE
  } state_t;

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Power-up init command order
  function automatic logic [7:0] init_byte(input logic [1:0] i);
    case (i)
      2'd0:    return LCD_FUNC_SET;
      2'd1:    return LCD_DISP_ON;
      2'd2:    return LCD_ENTRY;
      default: return LCD_CLEAR;
    endcase
  endfunction

endpackage

// File: rtl/lcd_msg_arbiter_byte_writer.sv
// lcd_byte_writer: one LCD bus write (setup / EN pulse / command wait) with a
// start/done handshake. Owns the single delay counter, which also times the
// power-up idle period (pwr=1: counts PWR_WAIT with EN low, bus untouched).
// Ports:
//   CLOCK, rst      clock, async active-low reset
//   start           begin a write (or power wait if pwr=1); accepted any cycle
//   pwr             select power-up wait instead of a byte write
//   rs_in, data_in  byte to write
//   done            high on the final wait cycle (combinational)
//   idle            no operation in progress
//   lcd_rs/en/data  registered LCD bus
module lcd_byte_writer
  import lcd_pkg::*;
#(
  parameter int SETUP_CYCLES = 3,
  parameter int EN_CYCLES    = 25,
  parameter int CMD_WAIT     = 2000,
  parameter int CLR_WAIT     = 80000,
  parameter int PWR_WAIT     = 1000000
) (
  input  logic       CLOCK,
  input  logic       rst,
  input  logic       start,
  input  logic       pwr,
  input  logic       rs_in,
  input  logic [7:0] data_in,
  output logic       done,
  output logic       idle,
  output logic       lcd_rs,
  output logic       lcd_en,
  output logic [7:0] lcd_data
);

  localparam int MAXC = imax(imax(imax(SETUP_CYCLES, EN_CYCLES), imax(CMD_WAIT, CLR_WAIT)), PWR_WAIT);
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic [1:0] {W_IDLE, W_SETUP, W_EN, W_WAIT} wphase_t;

  wphase_t       phase;
  logic [CW-1:0] cnt;
  logic [CW-1:0] wait_len;

  assign done = (phase == W_WAIT) && (cnt == wait_len);
  assign idle = (phase == W_IDLE);

  // Counts run 1..N so each phase lasts exactly its parameter in cycles.
  always_ff @(posedge CLOCK or negedge rst) begin
    if (!rst) begin
      phase    <= W_IDLE;
      cnt      <= '0;
      wait_len <= '0;
      lcd_rs   <= 1'b0;
      lcd_en   <= 1'b0;
      lcd_data <= 8'h00;
    end else if (start) begin
      cnt    <= CW'(1);
      lcd_en <= 1'b0;
      if (pwr) begin
        phase    <= W_WAIT;
        wait_len <= CW'(PWR_WAIT);
      end else begin
        phase    <= W_SETUP;
        lcd_rs   <= rs_in;
        lcd_data <= data_in;
        wait_len <= (!rs_in && data_in == LCD_CLEAR) ? CW'(CLR_WAIT) : CW'(CMD_WAIT);
      end
    end else begin
      case (phase)
        W_SETUP: if (cnt == CW'(SETUP_CYCLES)) begin
          phase  <= W_EN;
          lcd_en <= 1'b1;
          cnt    <= CW'(1);
        end else cnt <= cnt + 1'b1;
        W_EN: if (cnt == CW'(EN_CYCLES)) begin
          phase  <= W_WAIT;
          lcd_en <= 1'b0;
          cnt    <= CW'(1);
        end else cnt <= cnt + 1'b1;
        W_WAIT: if (done) phase <= W_IDLE;
                else      cnt   <= cnt + 1'b1;
        default: phase <= W_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/lcd_msg_arbiter.sv
// lcd_msg_arbiter: shares a 16x2 LCD between two 32-char message sources.
// Power-up wait, init sequence, then round-robin grants; each grant latches
// the 256-bit message and streams 34 byte writes (line addresses + chars).
// Optional macro LCD_CLEAR_ON_SWITCH_EN: prefix a clear when ownership changes.
// Ports:
//   CLOCK, rst      clock, async active-low reset
//   req[1:0]        level requests, held until ack
//   msg0, msg1      messages, char 0 in [255:248]
//   ack[1:0]        one-cycle done pulse per requester
//   busy            high outside IDLE
//   owner           last-granted requester
//   LCD_RS/RW/EN/DATA  LCD bus (RW tied 0)
module lcd_msg_arbiter
  import lcd_pkg::*;
#(
  parameter int SETUP_CYCLES = 3,
  parameter int EN_CYCLES    = 25,
  parameter int CMD_WAIT     = 2000,
  parameter int CLR_WAIT     = 80000,
  parameter int PWR_WAIT     = 1000000
) (
  input  logic         CLOCK,
  input  logic         rst,
  input  logic [1:0]   req,
  input  logic [255:0] msg0,
  input  logic [255:0] msg1,
  output logic [1:0]   ack,
  output logic         busy,
  output logic         owner,
  output logic         LCD_RS,
  output logic         LCD_RW,
  output logic         LCD_EN,
  output logic [7:0]   LCD_DATA
);

  state_t       state;
  logic [5:0]   idx;        // next byte to issue
  logic [255:0] msg_buf;
  logic         grant;
  logic         clr_first;  // transfer starts with an extra clear

  logic         wr_start, wr_pwr, wr_rs, wr_done, wr_idle;
  logic [7:0]   wr_data;
  logic [5:0]   total, bi;
  logic [4:0]   k;

  assign LCD_RW = 1'b0;
  assign total  = 6'(MSG_BYTES) + {5'b0, clr_first};
  assign bi     = idx - {5'b0, clr_first};
  assign k      = (bi < 6'd17) ? 5'(bi - 6'd1) : 5'(bi - 6'd2);

  // Next write is issued on the same edge the previous one finishes, so
  // back-to-back bytes carry no handshake bubble.
  always_comb begin
    wr_start = 1'b0;
    wr_pwr   = 1'b0;
    wr_rs    = 1'b0;
    wr_data  = 8'h00;
    case (state)
      ST_PWR: begin
        wr_pwr   = 1'b1;
        wr_start = wr_idle;
      end
      ST_INIT: begin
        wr_data  = init_byte(idx[1:0]);
        wr_start = (wr_idle || wr_done) && (idx != 6'd4);
      end
      ST_XFER: begin
        wr_start = (wr_idle || wr_done) && (idx != total);
        if (clr_first && idx == 6'd0) wr_data = LCD_CLEAR;
        else if (bi == 6'd0)          wr_data = LCD_LINE1;
        else if (bi == 6'd17)         wr_data = LCD_LINE2;
        else begin
          wr_rs   = 1'b1;
          // {~k,3'b111} == 255 - 8*k
          wr_data = msg_buf[{~k, 3'b111} -: 8];
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLOCK or negedge rst) begin
    if (!rst) begin
      state     <= ST_PWR;
      idx       <= '0;
      msg_buf   <= '0;
      grant     <= 1'b0;
      clr_first <= 1'b0;
      ack       <= 2'b00;
      busy      <= 1'b1;
      owner     <= 1'b0;
    end else begin
      case (state)
        ST_PWR: if (wr_done) begin
          state <= ST_INIT;
          idx   <= '0;
        end
        ST_INIT: begin
          if (wr_start) idx <= idx + 1'b1;
          if (wr_done && idx == 6'd4) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        ST_IDLE: if (req != 2'b00) begin
          // Both requesting: serve the one that did not go last.
          grant <= (req == 2'b11) ? ~owner : req[1];
          state <= ST_GRANT;
          busy  <= 1'b1;
        end
        ST_GRANT: begin
          msg_buf <= grant ? msg1 : msg0;
          owner   <= grant;
`ifdef LCD_CLEAR_ON_SWITCH_EN
          clr_first <= (grant != owner);
`else
          clr_first <= 1'b0;
`endif
          idx   <= '0;
          state <= ST_XFER;
        end
        ST_XFER: begin
          if (wr_start) idx <= idx + 1'b1;
          if (wr_done && idx == total) begin
            state <= ST_DONE;
            ack   <= owner ? 2'b10 : 2'b01;
          end
        end
        ST_DONE: begin
          ack   <= 2'b00;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_PWR;
      endcase
    end
  end

  lcd_byte_writer #(
    .SETUP_CYCLES(SETUP_CYCLES), .EN_CYCLES(EN_CYCLES), .CMD_WAIT(CMD_WAIT),
    .CLR_WAIT(CLR_WAIT), .PWR_WAIT(PWR_WAIT)
  ) u_wr (
    .CLOCK(CLOCK), .rst(rst), .start(wr_start), .pwr(wr_pwr),
    .rs_in(wr_rs), .data_in(wr_data), .done(wr_done), .idle(wr_idle),
    .lcd_rs(LCD_RS), .lcd_en(LCD_EN), .lcd_data(LCD_DATA)
  );

endmodule
